// File: rtl/noc_test_node.sv
// NoC mesh endpoint: injects NUM_PKTS fixed-length packets to one destination
// and counts received packets whose header is addressed to this node.
module noc_test_node #(
  parameter int X_ID           = 0,
  parameter int Y_ID           = 0,
  parameter int DEST_X_ID      = 1,
  parameter int DEST_Y_ID      = 1,
  parameter int PKT_LEN        = 4,
  parameter int NUM_PKTS       = 16,
  parameter int GAP_CYCLES     = 2,
  parameter int Noc_Data_Width = 32
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst_n,
  input  logic                      receive_valid,
  output logic                      receive_ready,
  input  logic [Noc_Data_Width-1:0] receive_flit,
  input  logic                      receive_is_header,
  input  logic                      receive_is_tail,
  output logic                      sender_valid,
  input  logic                      sender_ready,
  output logic [Noc_Data_Width-1:0] sender_flit,
  output logic                      sender_is_header,
  output logic                      sender_is_tail,
  output logic [7:0]                receive_num
);

  typedef enum logic [2:0] {IDLE, HEAD, BODY, GAP, DONE} state_t;

  localparam logic [7:0]  LAST_IDX = 8'(PKT_LEN - 1);
  localparam logic [7:0]  LAST_SEQ = 8'(NUM_PKTS - 1);
  localparam logic [15:0] LAST_GAP = 16'(GAP_CYCLES - 1);

  state_t      state;
  logic [7:0]  seq;
  logic [7:0]  idx;
  logic [15:0] gap_cnt;

  function automatic logic [Noc_Data_Width-1:0] head_flit(input logic [7:0] s);
    logic [Noc_Data_Width-1:0] f;
    f        = '0;
    f[23:16] = s;
    f[15:12] = 4'(X_ID);
    f[11:8]  = 4'(Y_ID);
    f[7:4]   = 4'(DEST_X_ID);
    f[3:0]   = 4'(DEST_Y_ID);
    return f;
  endfunction

  function automatic logic [Noc_Data_Width-1:0] body_flit(input logic [7:0] s,
                                                          input logic [7:0] i);
    logic [Noc_Data_Width-1:0] f;
    f        = '0;
    f[23:16] = s;
    f[7:0]   = i;
    return f;
  endfunction

  // The next header is loaded on the edge that leaves GAP (or accepts the tail
  // when GAP_CYCLES is 0), so packets are spaced by exactly GAP_CYCLES idle cycles.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state            <= IDLE;
      seq              <= '0;
      idx              <= '0;
      gap_cnt          <= '0;
      sender_valid     <= 1'b0;
      sender_flit      <= '0;
      sender_is_header <= 1'b0;
      sender_is_tail   <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= HEAD;
        HEAD: begin
          if (!sender_valid) begin
            sender_valid     <= 1'b1;
            sender_flit      <= head_flit(seq);
            sender_is_header <= 1'b1;
            sender_is_tail   <= 1'b0;
          end else if (sender_ready) begin
            state            <= BODY;
            idx              <= 8'd1;
            sender_flit      <= body_flit(seq, 8'd1);
            sender_is_header <= 1'b0;
            sender_is_tail   <= (LAST_IDX == 8'd1);
          end
        end
        BODY: begin
          if (sender_ready) begin
            if (idx == LAST_IDX) begin
              sender_valid     <= 1'b0;
              sender_flit      <= '0;
              sender_is_header <= 1'b0;
              sender_is_tail   <= 1'b0;
              gap_cnt          <= '0;
              if (GAP_CYCLES != 0) begin
                state <= GAP;
              end else if (seq == LAST_SEQ) begin
                state <= DONE;
              end else begin
                state            <= HEAD;
                seq              <= seq + 8'd1;
                sender_valid     <= 1'b1;
                sender_flit      <= head_flit(seq + 8'd1);
                sender_is_header <= 1'b1;
              end
            end else begin
              idx            <= idx + 8'd1;
              sender_flit    <= body_flit(seq, idx + 8'd1);
              sender_is_tail <= ((idx + 8'd1) == LAST_IDX);
            end
          end
        end
        GAP: begin
          if (gap_cnt == LAST_GAP) begin
            if (seq == LAST_SEQ) begin
              state <= DONE;
            end else begin
              state            <= HEAD;
              seq              <= seq + 8'd1;
              sender_valid     <= 1'b1;
              sender_flit      <= head_flit(seq + 8'd1);
              sender_is_header <= 1'b1;
              sender_is_tail   <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        DONE: begin
          sender_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic take;
  logic addr_hit;
  logic in_packet;
  logic match;
  logic unused_flit_bits;

  assign take             = receive_valid && receive_ready;
  assign addr_hit         = (receive_flit[7:4] == 4'(X_ID)) && (receive_flit[3:0] == 4'(Y_ID));
  assign unused_flit_bits = ^receive_flit[Noc_Data_Width-1:8];

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      receive_ready <= 1'b0;
      in_packet     <= 1'b0;
      match         <= 1'b0;
      receive_num   <= '0;
    end else begin
      receive_ready <= 1'b1;
      if (take) begin
        if (receive_is_header) begin
          match <= addr_hit;
          if (receive_is_tail) begin
            in_packet <= 1'b0;
            if (addr_hit) receive_num <= receive_num + 8'd1;
          end else begin
            in_packet <= 1'b1;
          end
        end else if (receive_is_tail && in_packet) begin
          in_packet <= 1'b0;
          if (match) receive_num <= receive_num + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_test_node.sv
// Directed bench: generator looped into a (1,1) sink, plus a tb-driven (1,1) receiver.
module tb_noc_test_node;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  logic        gen_valid, gen_ready, gen_hdr, gen_tail, gen_rready;
  logic [31:0] gen_flit;
  logic [7:0]  gen_num;
  logic        tie0;
  logic [31:0] tie0_flit;

  logic        sink_in_valid, sink_rready, sink_svalid, sink_shdr, sink_stail;
  logic [31:0] sink_sflit;
  logic [7:0]  sink_num;

  logic        chk_valid, chk_hdr, chk_tail, chk_rready, chk_svalid, chk_shdr, chk_stail;
  logic [31:0] chk_flit, chk_sflit;
  logic [7:0]  chk_num;

  assign tie0          = 1'b0;
  assign tie0_flit     = '0;
  assign sink_in_valid = gen_valid && gen_ready;

  noc_test_node u_gen (
    .noc_clk(clk), .noc_rst_n(rst_n),
    .receive_valid(tie0), .receive_ready(gen_rready), .receive_flit(tie0_flit),
    .receive_is_header(tie0), .receive_is_tail(tie0),
    .sender_valid(gen_valid), .sender_ready(gen_ready), .sender_flit(gen_flit),
    .sender_is_header(gen_hdr), .sender_is_tail(gen_tail), .receive_num(gen_num)
  );

  noc_test_node #(.X_ID(1), .Y_ID(1)) u_sink (
    .noc_clk(clk), .noc_rst_n(rst_n),
    .receive_valid(sink_in_valid), .receive_ready(sink_rready), .receive_flit(gen_flit),
    .receive_is_header(gen_hdr), .receive_is_tail(gen_tail),
    .sender_valid(sink_svalid), .sender_ready(tie0), .sender_flit(sink_sflit),
    .sender_is_header(sink_shdr), .sender_is_tail(sink_stail), .receive_num(sink_num)
  );

  noc_test_node #(.X_ID(1), .Y_ID(1), .NUM_PKTS(1)) u_chk (
    .noc_clk(clk), .noc_rst_n(rst_n),
    .receive_valid(chk_valid), .receive_ready(chk_rready), .receive_flit(chk_flit),
    .receive_is_header(chk_hdr), .receive_is_tail(chk_tail),
    .sender_valid(chk_svalid), .sender_ready(tie0), .sender_flit(chk_sflit),
    .sender_is_header(chk_shdr), .sender_is_tail(chk_stail), .receive_num(chk_num)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Drives one packet into u_chk, one flit per cycle, starting at a negedge.
  task automatic send_pkt(input logic [3:0] dx, input logic [3:0] dy, input int len,
                          input logic [7:0] s);
    for (int i = 0; i < len; i++) begin
      chk_valid = 1'b1;
      chk_flit  = (i == 0) ? {8'h00, s, 8'h00, dx, dy} : {8'h00, s, 8'h00, 8'(i)};
      chk_hdr   = (i == 0);
      chk_tail  = (i == len - 1);
      @(negedge clk);
    end
    chk_valid = 1'b0;
    chk_hdr   = 1'b0;
    chk_tail  = 1'b0;
  endtask

  initial begin
    int          acc, mseq, midx;
    logic        pv, pr, ph, pt, seen;
    logic [31:0] pf, want;

    gen_ready = 1'b1;
    chk_valid = 1'b0;
    chk_flit  = '0;
    chk_hdr   = 1'b0;
    chk_tail  = 1'b0;

    // Reset and idle
    repeat (10) @(negedge clk);
    chk("rst_valid", gen_valid, 1'b0);
    chk("rst_flit", gen_flit, 32'h0);
    chk("rst_marks", {gen_hdr, gen_tail}, 2'b00);
    chk("rst_rready", gen_rready, 1'b0);
    chk("rst_num", gen_num, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_valid", gen_valid, 1'b0);
    chk("rready_up", gen_rready, 1'b1);
    @(negedge clk);
    chk("hdr0_valid", gen_valid, 1'b1);
    chk("hdr0_flit", gen_flit, 32'h0000_0011);
    chk("hdr0_marks", {gen_hdr, gen_tail}, 2'b10);
    @(negedge clk);
    chk("idx1_flit", gen_flit, 32'h0000_0001);
    @(negedge clk);
    chk("idx2_flit", gen_flit, 32'h0000_0002);
    chk("idx2_marks", {gen_hdr, gen_tail}, 2'b00);
    @(negedge clk);
    chk("tail_flit", gen_flit, 32'h0000_0003);
    chk("tail_marks", {gen_hdr, gen_tail}, 2'b01);
    @(negedge clk);
    chk("gap1_valid", gen_valid, 1'b0);
    @(negedge clk);
    chk("gap2_valid", gen_valid, 1'b0);
    @(negedge clk);
    chk("hdr1_flit", gen_flit, 32'h0001_0011);
    chk("hdr1_valid", gen_valid, 1'b1);

    // Loopback to the end of generation
    for (int c = 0; c < 400 && sink_num != 8'd16; c++) @(negedge clk);
    chk("loop_num", sink_num, 8'd16);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | gen_valid;
    end
    chk("done_quiet", seen, 1'b0);
    chk("loop_num_final", sink_num, 8'd16);

    // Backpressure with ready pattern 1,0,0,1
    rst_n = 1'b0;
    gen_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acc = 0; mseq = 0; midx = 0;
    pv = 1'b0; pr = 1'b0; ph = 1'b0; pt = 1'b0; pf = '0;
    for (int c = 0; c < 1000 && acc < 64; c++) begin
      @(negedge clk);
      if (pv && !pr) begin
        chk("bp_hold_valid", gen_valid, 1'b1);
        chk("bp_hold_flit", gen_flit, pf);
        chk("bp_hold_marks", {gen_hdr, gen_tail}, {ph, pt});
      end
      if (pv && pr) begin
        want = (midx == 0) ? {8'h00, 8'(mseq), 16'h0011} : {8'h00, 8'(mseq), 8'h00, 8'(midx)};
        chk("bp_flit", pf, want);
        chk("bp_marks", {ph, pt}, {midx == 0, midx == 3});
        acc++;
        midx = (midx == 3) ? 0 : midx + 1;
        if (midx == 0) mseq++;
      end
      pv = gen_valid; pf = gen_flit; ph = gen_hdr; pt = gen_tail;
      gen_ready = ((c % 4) == 0) || ((c % 4) == 3);
      pr = gen_ready;
    end
    chk("bp_flit_count", acc, 32'd64);
    for (int c = 0; c < 100 && sink_num != 8'd16; c++) @(negedge clk);
    chk("bp_sink_num", sink_num, 8'd16);

    // Address filter on u_chk at (1,1)
    send_pkt(4'd1, 4'd1, 4, 8'd0);
    chk("af_match1", chk_num, 8'd1);
    send_pkt(4'd0, 4'd1, 3, 8'd1);
    chk("af_miss1", chk_num, 8'd1);
    send_pkt(4'd1, 4'd1, 2, 8'd2);
    send_pkt(4'd0, 4'd1, 4, 8'd3);
    send_pkt(4'd1, 4'd1, 4, 8'd4);
    chk("af_total", chk_num, 8'd3);
    send_pkt(4'd1, 4'd1, 1, 8'd5);
    chk("single_flit", chk_num, 8'd4);

    // Orphan body and tail
    chk_valid = 1'b1; chk_flit = 32'h0000_0001; chk_hdr = 1'b0; chk_tail = 1'b0;
    @(negedge clk);
    chk_flit = 32'h0000_0002; chk_tail = 1'b1;
    @(negedge clk);
    chk_valid = 1'b0; chk_tail = 1'b0;
    @(negedge clk);
    chk("orphan", chk_num, 8'd4);

    // Wrap of the received count
    for (int p = 0; p < 251; p++) send_pkt(4'd1, 4'd1, 2, 8'(p));
    chk("num_255", chk_num, 8'd255);
    send_pkt(4'd1, 4'd1, 2, 8'd0);
    chk("num_wrap", chk_num, 8'd0);

    // Reset mid-packet
    rst_n = 1'b0;
    gen_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_hdr", gen_flit, 32'h0000_0011);
    repeat (2) @(negedge clk);
    chk("mid_idx2", gen_flit, 32'h0000_0002);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", gen_valid, 1'b0);
    chk("async_flit", gen_flit, 32'h0);
    chk("async_marks", {gen_hdr, gen_tail}, 2'b00);
    chk("async_rready", gen_rready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("restart_valid", gen_valid, 1'b1);
    chk("restart_hdr", gen_flit, 32'h0000_0011);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/noc_test_node.md
# noc_test_node

Traffic-generator and sink endpoint for one NoC mesh port. It injects a fixed number of fixed-length packets addressed to a configured destination node, and counts the packets it receives that are addressed to itself. It sits on the local port of a router in the mesh fabric, alongside empty (idle) endpoints, and serves as the simulation stimulus and checker for the fabric.

## Interface
- `X_ID`, default 0: own X coordinate (4 bits used).
- `Y_ID`, default 0: own Y coordinate (4 bits used).
- `DEST_X_ID`, default 1: X coordinate of the destination for generated packets.
- `DEST_Y_ID`, default 1: Y coordinate of the destination for generated packets.
- `PKT_LEN`, default 4: flits per packet (header + body + tail); must be at least 2.
- `NUM_PKTS`, default 16: packets to inject after reset; range 1..255.
- `GAP_CYCLES`, default 2: idle cycles between packets.
- `noc_clk`  in  1  the single clock; all logic is on the rising edge.
- `noc_rst_n`  in  1  asynchronous, active-low reset.
- `receive_valid`  in  1  inbound flit valid, from the router.
- `receive_ready`  out  1  inbound ready.
- `receive_flit`  in  `Noc_Data_Width`  inbound flit (width 32 by default).
- `receive_is_header`  in  1  inbound flit is the first flit of a packet.
- `receive_is_tail`  in  1  inbound flit is the last flit of a packet.
- `sender_valid`  out  1  outbound flit valid, to the router.
- `sender_ready`  in  1  router accepts the outbound flit.
- `sender_flit`  out  `Noc_Data_Width`  outbound flit.
- `sender_is_header`  out  1  outbound header marker.
- `sender_is_tail`  out  1  outbound tail marker.
- `receive_num`  out  8  count of correctly addressed packets received.

## Operation
**Flit transfer**
- A flit transfers on a rising edge where valid and ready are both 1.

**Header flit format**
- [3:0] = destination Y.
- [7:4] = destination X.
- [11:8] = source Y.
- [15:12] = source X.
- [23:16] = packet sequence number (0..NUM_PKTS-1).
- Remaining upper bits are 0.

**Body and tail flit format**
- [23:16] = sequence number.
- [7:0] = flit index (1..PKT_LEN-1).
- All other bits are 0.
- The tail flit is index PKT_LEN-1.

**Sender state machine**
- States: IDLE, HEAD, BODY, GAP, DONE.
- IDLE → HEAD on the first edge after reset is released.
- HEAD drives the header flit: `sender_is_header`=1, `sender_is_tail`=0. On acceptance → BODY with index 1.
- BODY drives the flit for the current index. `sender_is_tail`=1 only when index = PKT_LEN-1. On acceptance the index increments; acceptance of the tail → GAP.
- GAP holds `sender_valid`=0 for GAP_CYCLES cycles (0 means skip), then → HEAD with sequence+1. After packet NUM_PKTS-1 it goes → DONE instead.
- DONE: `sender_valid`=0 permanently until the next reset.
- While `sender_valid`=1 and `sender_ready`=0, the flit and both markers are held stable.
- `sender_valid` never drops before acceptance.

**Receiver**
- `receive_ready`=1 whenever out of reset; the receiver never back-pressures.
- On an accepted header, latch match = (flit[7:4]==X_ID && flit[3:0]==Y_ID) and set in_packet.
- On an accepted tail while in_packet and match: `receive_num` += 1, wrapping 255 → 0. Then clear in_packet.
- A flit that is both header and tail counts as a 1-flit packet.
- Mismatched packets are consumed but not counted.
- Body or tail flits arriving with in_packet=0 are ignored.

## Timing
**Reset values**
- `sender_valid`=0, `sender_flit`=0, `sender_is_header`=0, `sender_is_tail`=0.
- `receive_ready`=0, `receive_num`=0.
- Sequence, index and FSM state = IDLE.
- Asserting reset mid-packet abandons the packet immediately (asynchronous); after release, generation restarts from sequence 0.

**Sender latency**
- The first header is valid from the second rising edge after reset release (1 edge in IDLE).
- With `sender_ready` held at 1, one packet occupies PKT_LEN consecutive cycles, followed by GAP_CYCLES idle cycles.

**Receiver latency**
- `receive_num` updates at the same edge that accepts the qualifying tail, so it is visible in the following cycle.
- `receive_ready` rises at the first edge after reset release.

**Outputs**
- All outputs are registered.

## Test plan
- Reset and idle:
  - Stimulus: hold reset low for 10 cycles with `sender_ready`=1.
  - Required: all outputs are 0; after release, `sender_valid` rises at the 2nd edge and the header flit = 0x0000_0011 (src 0,0 to dest 1,1, seq 0).
- Loopback (sender outputs wired to the inputs of a second instance with X_ID=1, Y_ID=1):
  - Required: the second instance's `receive_num` = 16 after all packets.
  - Required: the sender enters DONE and `sender_valid` stays 0.
- Backpressure:
  - Stimulus: `sender_ready` toggles 1,0,0,1 repeatedly.
  - Required: the flit and markers stay stable while stalled; the flit sequence is exactly header, idx1, idx2, tail per packet, with no loss or duplication.
- Address filter:
  - Stimulus: inject 3 packets to (1,1) and 2 packets to (0,1) into the node with X_ID=1, Y_ID=1.
  - Required: `receive_num` = 3.
- Orphan and wrap:
  - Stimulus: a body/tail without a header.
  - Required: no count.
  - Stimulus: 256 matched packets.
  - Required: `receive_num` wraps to 0.
- Reset mid-packet:
  - Stimulus: assert `noc_rst_n` low after the body index-1 flit has been accepted.
  - Required: outputs clear asynchronously; after release, the next header carries seq 0.
